// File: rtl/video_ula.sv
// rtl/video_ula.sv - display ULA: character-clock enable, byte serialiser, palette, cursor overlay, RGB and sync output
module video_ula #(
  parameter int SYNC_DELAY = 2
) (
  input  logic       pixel_clk,
  input  logic       RESET,
  input  logic       nCS,
  input  logic       A0,
  input  logic       wr_en,
  input  logic [7:0] data_bus,
  input  logic [7:0] vid_data,
  input  logic       display_en,
  input  logic       cursor,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic [2:0] ttx_rgb,
  output logic       char_clk_en,
  output logic       R,
  output logic       G,
  output logic       B,
  output logic       h_sync,
  output logic       v_sync
);

  typedef enum logic [2:0] {
    CUR_IDLE,
    CUR_SEG0,
    CUR_SEG1,
    CUR_SEG2,
    CUR_SEG3
  } cur_state_t;

  logic [7:0]      ctl;
  logic [7:0]      ctl_d;
  logic [7:0]      act_ctl;
  logic [3:0]      pal [16];
  logic [3:0]      ph;
  logic            ld_q;
  logic [7:0]      sr;
  logic [2:0]      sc;
  logic [2:0]      sc_last;
  logic            de_l;
  logic            ctl_wr;
  logic            pal_wr;
  cur_state_t      cur_state;
  cur_state_t      cur_state_nxt;
  logic            cur_on;
  logic [3:0]      logical;
  logic [3:0]      phys;
  logic [2:0]      rgb_pix;
  logic [SYNC_DELAY-1:0] hs_pipe;
  logic [SYNC_DELAY-1:0] vs_pipe;

  assign ctl_wr = wr_en & ~nCS & ~A0;
  assign pal_wr = wr_en & ~nCS & A0;

  // A control write in the load cycle must be seen by that load, so loads sample the next value
  always_comb begin
    ctl_d = ctl;
    if (ctl_wr) ctl_d = data_bus;
  end

  // Character rate comes from the active (byte-latched) control copy
  always_comb begin
    char_clk_en = act_ctl[4] ? (ph[2:0] == 3'b111) : (ph == 4'hF);
  end

  // Free-running phase counter; the cycle after char_clk_en is the byte-load cycle
  always_ff @(posedge pixel_clk) begin
    if (RESET) begin
      ph   <= 4'h0;
      ld_q <= 1'b0;
    end else begin
      ph   <= ph + 4'h1;
      ld_q <= char_clk_en;
    end
  end

  // CPU-visible control register
  always_ff @(posedge pixel_clk) begin
    if (RESET) ctl <= 8'h00;
    else       ctl <= ctl_d;
  end

  // Palette: entries reset to 7, which the output inversion turns into black
  always_ff @(posedge pixel_clk) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) pal[i] <= 4'h7;
    end else if (pal_wr) begin
      pal[data_bus[7:4]] <= data_bus[3:0];
    end
  end

  // Shift period minus one for the active shift rate (2/4/8/16 MHz)
  always_comb begin
    sc_last = 3'd7;
    case (act_ctl[3:2])
      2'b00: sc_last = 3'd7;
      2'b01: sc_last = 3'd3;
      2'b10: sc_last = 3'd1;
      2'b11: sc_last = 3'd0;
    endcase
  end

  // Byte load and pixel shifter; the counter restarts on load so the first pixel gets a full period
  always_ff @(posedge pixel_clk) begin
    if (RESET) begin
      sr      <= 8'h00;
      sc      <= 3'd0;
      de_l    <= 1'b0;
      act_ctl <= 8'h00;
    end else if (ld_q) begin
      sr      <= vid_data;
      sc      <= 3'd0;
      de_l    <= display_en;
      act_ctl <= ctl_d;
    end else if (sc == sc_last) begin
      sr <= {sr[6:0], 1'b1};
      sc <= 3'd0;
    end else begin
      sc <= sc + 3'd1;
    end
  end

  // Cursor segment state register
  always_ff @(posedge pixel_clk) begin
    if (RESET) cur_state <= CUR_IDLE;
    else       cur_state <= cur_state_nxt;
  end

  // Cursor next state: advances only on byte loads, a fresh pulse restarts at segment 0
  always_comb begin
    cur_state_nxt = cur_state;
    if (ld_q) begin
      if (cursor) begin
        cur_state_nxt = CUR_SEG0;
      end else begin
        case (cur_state)
          CUR_IDLE: cur_state_nxt = CUR_IDLE;
          CUR_SEG0: cur_state_nxt = CUR_SEG1;
          CUR_SEG1: cur_state_nxt = CUR_SEG2;
          CUR_SEG2: cur_state_nxt = CUR_SEG3;
          CUR_SEG3: cur_state_nxt = CUR_IDLE;
          default:  cur_state_nxt = CUR_IDLE;
        endcase
      end
    end
  end

  // Cursor output: each segment gated by its mask bit, segments 2 and 3 share one
  always_comb begin
    cur_on = 1'b0;
    case (cur_state)
      CUR_SEG0: cur_on = act_ctl[7];
      CUR_SEG1: cur_on = act_ctl[6];
      CUR_SEG2: cur_on = act_ctl[5];
      CUR_SEG3: cur_on = act_ctl[5];
      default:  cur_on = 1'b0;
    endcase
  end

  // Pixel colour: palette or teletext, then blanking, then cursor inversion; bit order {B,G,R}
  always_comb begin
    logical = {sr[7], sr[5], sr[3], sr[1]};
    phys    = pal[logical];
    rgb_pix = phys[2:0] ^ 3'b111;
    if (phys[3] & act_ctl[0]) rgb_pix = rgb_pix ^ 3'b111;
    if (act_ctl[1])           rgb_pix = ttx_rgb;
    if (!de_l)                rgb_pix = 3'b000;
    if (cur_on)               rgb_pix = rgb_pix ^ 3'b111;
  end

  // Registered RGB output
  always_ff @(posedge pixel_clk) begin
    if (RESET) begin
      R <= 1'b0;
      G <= 1'b0;
      B <= 1'b0;
    end else begin
      R <= rgb_pix[0];
      G <= rgb_pix[1];
      B <= rgb_pix[2];
    end
  end

  // Sync delay line keeping syncs aligned with the RGB pipeline
  always_ff @(posedge pixel_clk) begin
    if (RESET) begin
      hs_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      hs_pipe[0] <= h_sync_in;
      vs_pipe[0] <= v_sync_in;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign h_sync = hs_pipe[SYNC_DELAY-1];
  assign v_sync = vs_pipe[SYNC_DELAY-1];

endmodule

// File: tb/tb_video_ula.sv
// tb/tb_video_ula.sv - directed self-checking bench for video_ula
`timescale 1ns/1ps
module tb_video_ula;

  logic       pixel_clk = 1'b0;
  logic       RESET;
  logic       nCS;
  logic       A0;
  logic       wr_en;
  logic [7:0] data_bus;
  logic [7:0] vid_data;
  logic       display_en;
  logic       cursor;
  logic       h_sync_in;
  logic       v_sync_in;
  logic [2:0] ttx_rgb;
  logic       char_clk_en;
  logic       R, G, B;
  logic       h_sync, v_sync;
  logic [2:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #31.25 pixel_clk = ~pixel_clk;

  assign obs = {B, G, R};

  video_ula #(.SYNC_DELAY(2)) dut (
    .pixel_clk   (pixel_clk),
    .RESET       (RESET),
    .nCS         (nCS),
    .A0          (A0),
    .wr_en       (wr_en),
    .data_bus    (data_bus),
    .vid_data    (vid_data),
    .display_en  (display_en),
    .cursor      (cursor),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .ttx_rgb     (ttx_rgb),
    .char_clk_en (char_clk_en),
    .R           (R),
    .G           (G),
    .B           (B),
    .h_sync      (h_sync),
    .v_sync      (v_sync)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic wait_cce();
    int n;
    n = 0;
    @(negedge pixel_clk);
    while (!char_clk_en && n < 64) begin
      @(negedge pixel_clk);
      n++;
    end
    if (!char_clk_en) check("cce_timeout", 32'd0, 32'd1);
  endtask

  task automatic cce_period(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge pixel_clk);
      n++;
    end while (!char_clk_en && n < 40);
    check(tag, n, exp);
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    @(negedge pixel_clk);
    nCS = 1'b0; wr_en = 1'b1; A0 = a0; data_bus = d;
    @(negedge pixel_clk);
    nCS = 1'b1; wr_en = 1'b0; A0 = 1'b0; data_bus = 8'h00;
  endtask

  logic [2:0] cur_exp [7];
  int n;

  initial begin
    cur_exp = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b000};
    RESET = 1'b1; nCS = 1'b1; A0 = 1'b0; wr_en = 1'b0; data_bus = 8'h00;
    vid_data = 8'h00; display_en = 1'b0; cursor = 1'b0;
    h_sync_in = 1'b0; v_sync_in = 1'b0; ttx_rgb = 3'b000;

    skip(3);
    check("reset_rgb", obs, 3'b000);
    check("reset_cce", char_clk_en, 1'b0);
    check("reset_hsync", h_sync, 1'b0);
    check("reset_vsync", v_sync, 1'b0);
    RESET = 1'b0;

    // sync delay of two cycles
    h_sync_in = 1'b1; v_sync_in = 1'b1;
    @(negedge pixel_clk);
    check("hsync_d1", h_sync, 1'b0);
    h_sync_in = 1'b0; v_sync_in = 1'b0;
    @(negedge pixel_clk);
    check("hsync_d2", h_sync, 1'b1);
    check("vsync_d2", v_sync, 1'b1);

    // ctl = 0: 1 MHz character rate, default palette is black
    display_en = 1'b1; vid_data = 8'hFF;
    wait_cce();
    cce_period("cce_period_1mhz", 16);
    skip(3);
    check("black_default_a", obs, 3'b000);
    skip(5);
    check("black_default_b", obs, 3'b000);

    // 2 MHz chars, 16 MHz shift, alternating white/black
    wr(1'b1, 8'hF0);
    wr(1'b1, 8'h07);
    vid_data = 8'h00;
    wr(1'b0, 8'h9C);
    wait_cce(); wait_cce(); wait_cce();
    wait_cce();
    vid_data = 8'hAA;
    skip(2);
    check("prev_byte_last_px", obs, 3'b000);
    for (int j = 0; j < 8; j++) begin
      @(negedge pixel_clk);
      check($sformatf("alt_px%0d", j), obs, (j % 2 == 0) ? 3'b111 : 3'b000);
    end
    wait_cce();
    cce_period("cce_period_2mhz", 8);

    // 2 MHz shift, flash on then off
    wr(1'b1, 8'hF9);
    vid_data = 8'hFF;
    wr(1'b0, 8'h11);
    wait_cce(); wait_cce();
    wait_cce();
    skip(2);
    for (int j = 0; j < 8; j++) begin
      @(negedge pixel_clk);
      check($sformatf("flash_red%0d", j), obs, 3'b001);
    end
    wr(1'b0, 8'h10);
    wait_cce(); wait_cce();
    wait_cce();
    skip(3);
    check("flash_off_cyan", obs, 3'b110);

    // cursor mask 101, second pulse where segment 2 would be
    vid_data = 8'h00;
    wr(1'b0, 8'hBC);
    wait_cce(); wait_cce();
    wait_cce();
    for (int t = 0; t <= 51; t++) begin
      cursor = (t == 0 || t == 1 || t == 16 || t == 17);
      if (t >= 3 && (t - 3) % 8 == 0)
        check($sformatf("cursor_byte%0d", (t - 3) / 8), obs, cur_exp[(t - 3) / 8]);
      @(negedge pixel_clk);
    end
    cursor = 1'b0;

    // teletext pass-through, then blanking
    wr(1'b0, 8'h12);
    ttx_rgb = 3'b011; vid_data = 8'hFF;
    wait_cce(); wait_cce();
    wait_cce();
    skip(3);
    check("ttx_rgb", obs, 3'b011);
    wait_cce();
    display_en = 1'b0;
    skip(3);
    check("ttx_blank", obs, 3'b000);

    // reset mid-byte clears outputs, phase and palette
    display_en = 1'b1;
    wr(1'b1, 8'h50);
    wait_cce(); wait_cce();
    skip(6);
    check("pre_reset_ttx", obs, 3'b011);
    RESET = 1'b1;
    @(negedge pixel_clk);
    check("midreset_rgb", obs, 3'b000);
    check("midreset_cce", char_clk_en, 1'b0);
    RESET = 1'b0;
    vid_data = 8'hFF;
    n = 0;
    do begin
      @(negedge pixel_clk);
      n++;
    end while (!char_clk_en && n < 40);
    check("ph_restart", n, 15);
    skip(3);
    check("pal15_reset_black", obs, 3'b000);
    wait_cce();
    vid_data = 8'h22;
    skip(3);
    check("pal5_reset_black", obs, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_ula.md
Name: video_ula

Overview:
- Display-side partner of the MC6845 CRTC.
- Generates the CRTC character-clock enable and takes the fetched framestore byte plus display_en/cursor/syncs from the CRTC.
- Serialises the byte into pixels through a 16-entry palette and applies flash, cursor overlay and teletext pass-through.
- Drives 1-bit-per-gun RGB and registered syncs to the monitor.

Parameters:
- SYNC_DELAY, 2, pixel-clock stages applied to h_sync/v_sync so they stay aligned with RGB.

Ports:
- pixel_clk  in  1  16 MHz pixel clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- nCS  in  1  ULA register select, active low.
- A0  in  1  0 = control register, 1 = palette.
- wr_en  in  1  one-cycle write strobe, qualified by ~nCS.
- data_bus  in  8  CPU write data.
- vid_data  in  8  framestore byte fetched at the CRTC address.
- display_en  in  1  from the CRTC.
- cursor  in  1  from the CRTC.
- h_sync_in  in  1  from the CRTC.
- v_sync_in  in  1  from the CRTC.
- ttx_rgb  in  3  teletext generator RGB.
- char_clk_en  out  1  one-cycle enable to the CRTC.
- R  out  1  red.
- G  out  1  green.
- B  out  1  blue.
- h_sync  out  1  delayed sync.
- v_sync  out  1  delayed sync.

Behaviour:
- Registers:
  - Control register ctl[7:0], written when wr_en & ~nCS & ~A0.
  - ctl[7:5] is the cursor segment mask.
  - ctl[4] = 1 selects 2 MHz character rate, 0 selects 1 MHz.
  - ctl[3:2] is the shift rate: 00 = 2, 01 = 4, 10 = 8, 11 = 16 MHz.
  - ctl[1] = teletext select; ctl[0] = flash state.
- Palette:
  - Written when wr_en & ~nCS & A0: pal[data_bus[7:4]] <= data_bus[3:0].
  - Writes take effect on the next pixel.
  - Control writes take effect at the next byte load.
- Phase counter:
  - Free-running 4-bit phase counter ph.
  - char_clk_en = 1 when ph[2:0] == 7 (2 MHz) or ph == 15 (1 MHz).
- Byte load:
  - Occurs in the cycle after char_clk_en.
  - Latches vid_data into 8-bit shift register sr, and latches display_en and cursor.
  - Active ctl fields are sampled at the same point.
- Shifting:
  - sr shifts left by one, filling 1, every 8/4/2/1 cycles for shift rates 2/4/8/16 MHz.
  - The shift is aligned so the first pixel of each byte lasts a full shift period.
- Pixel colour:
  - Logical colour is {sr[7],sr[5],sr[3],sr[1]}.
  - Physical colour is p = pal[logical].
  - RGB = p[2:0] ^ 3'b111, additionally ^ 3'b111 when p[3] & ctl[0].
- Teletext: when ctl[1] = 1, RGB = ttx_rgb and the palette is bypassed.
- Blanking: when the latched display_en = 0, RGB = 000 before the cursor overlay.
- Cursor:
  - A latched cursor = 1 starts a 4-character segment counter seg = 0..3, advanced at each byte load.
  - Segment 0 is enabled by ctl[7], segment 1 by ctl[6], segments 2 and 3 by ctl[5].
  - In an enabled segment, RGB is inverted (XOR 111), including during blanking.
  - A new cursor pulse mid-sequence restarts seg at 0.
- Latency:
  - RGB is registered, one pixel_clk after sr/palette lookup.
  - The first pixel of a byte appears 2 cycles after the load.
  - h_sync/v_sync are delayed SYNC_DELAY cycles to match.
- Reset values: ph = 0, ctl = 0, all pal = 4'h7 (black), sr = 0, seg idle, R = G = B = 0, h_sync = v_sync = 0, char_clk_en = 0.
- Simultaneous events:
  - A write on a byte-load cycle lands first: ctl is sampled with the new value, and the palette write is visible on that byte.
  - RESET asserted mid-line clears everything on the next edge, and ph restarts from 0.
- States: shift rates are decoded from ctl; the cursor FSM has states IDLE, SEG0, SEG1, SEG2, SEG3, then returns to IDLE.

Test Plan:
- Reset, then free-run with ctl = 0x00 -> char_clk_en pulses every 16 cycles; RGB stays 000 for all pixels.
- ctl = 0x9C (2 MHz, 16 MHz shift), pal[15] = 0x0, pal[0] = 0x7, vid_data = 0xAA, display_en = 1 -> pixels alternate white/black at a 1-cycle period, first pixel 2 cycles after load; char_clk_en every 8 cycles.
- ctl = 0x10 (2 MHz, 2 MHz shift), vid_data = 0xFF, pal[15] = 0x9, ctl[0] toggled -> red, then cyan after the flash toggle, held for 8 cycles.
- Cursor = 1 for one char with ctl[7:5] = 101 -> segments 0, 2, 3 inverted and segment 1 normal; a second pulse at seg = 2 restarts at seg 0.
- ctl[1] = 1, ttx_rgb = 011 -> RGB = 011 irrespective of palette; display_en = 0 -> 000.
- Assert RESET mid-byte -> next edge R = G = B = 0 and ph = 0; palette reads back black on all entries.
